regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write/dual-read integer register file in the decode stage.
- Adds configurable read/write port counts, optional write-to-read bypass, and a per-register busy scoreboard for pipeline hazard detection.
- Sits in inst_decode.
  - Read ports feed the operand muxes.
  - Write ports are driven by writeback lanes.
  - The issue port marks destination registers pending until their writeback.

Parameters:
- REG_WIDTH, 32, data width per register.
- REG_DEPTH, 32, number of architectural registers (power of two).
- REG_ADDR_WIDTH, 5, log2(REG_DEPTH).
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return pre-write contents.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RegWEn  in  NUM_WR  per-lane write enable.
- addrD  in  NUM_WR*REG_ADDR_WIDTH  per-lane destination address; lane k at bits [k*AW +: AW].
- dataD  in  NUM_WR*REG_WIDTH  per-lane write data.
- addrR  in  NUM_RD*REG_ADDR_WIDTH  per-port read address.
- dataR  out  NUM_RD*REG_WIDTH  per-port read data (combinational).
- busyR  out  NUM_RD  per-port scoreboard bit of the addressed register (combinational).
- issue_en  in  1  mark issue_addr pending.
- issue_addr  in  REG_ADDR_WIDTH  destination being issued.
- busy_cnt  out  REG_ADDR_WIDTH+1  registered count of pending registers.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset dominates every write and issue in the same cycle.
- Reset values:
  - All Reg[i] = 0.
  - All busy[i] = 0.
  - busy_cnt = 0.
  - dataR = 0 for every port (all regs zero).
  - busyR = 0.
- Register x0:
  - Writes to address 0 are ignored.
  - issue_addr = 0 never sets busy.
  - Reads of address 0 return 0 and busyR = 0, regardless of BYPASS.
- Write:
  - On the edge, Reg[addrD_k] <= dataD_k for each lane with RegWEn[k]=1 and addrD_k != 0.
  - Write latency is 1 cycle.
- Write conflict: two lanes with the same non-zero address in the same cycle -> highest lane index wins.
- Read: dataR_j = Reg[addrR_j], combinational, zero cycles.
- BYPASS=1:
  - If any enabled lane writes addrR_j (!=0) this cycle, dataR_j = that lane's dataD.
  - Highest lane wins, as for write conflicts.
- BYPASS=0: dataR_j returns the stored value; the new value is visible the cycle after the edge.
- Scoreboard:
  - Each edge, busy[a] is cleared for every enabled write lane a != 0.
  - Then busy[issue_addr] is set if issue_en=1 and issue_addr != 0.
  - Issue and writeback to the same register in the same cycle -> busy ends set (issue wins).
- Issue to an already-busy register: busy stays 1; busy_cnt does not change.
- Write to a non-busy register: data is written normally; busy and busy_cnt are unchanged.
- busyR_j = busy[addrR_j], combinational.
  - No bypass of the clear: a reg being written this cycle still reads busy=1 until the edge.
- busy_cnt:
  - Registered; equals popcount(busy) after each edge.
  - Range 0..REG_DEPTH-1, so it cannot overflow.
- Reset mid-operation: pending issues and writes in the reset cycle are discarded; all state returns to reset values on that edge.

Test Plan:
- Reset, then write lane0 addr1=255, next cycle addr2=254 (RegWEn=1), then read A=1, B=2 with RegWEn=0 -> dataR0=255, dataR1=254.
- Write addr0=32'hFFFF, then read addr0 on both ports -> dataR=0; dump all 32 regs -> only Reg[1]=255 and Reg[2]=254 are non-zero.
- BYPASS=1, write addr5=32'hA5A5 while addrR0=5 -> dataR0=32'hA5A5 in the same cycle.
  - BYPASS=0, same stimulus -> old value (0) in that cycle, 32'hA5A5 the next cycle.
- NUM_WR=2, both lanes write addr7 (lane0=11, lane1=22) -> Reg[7]=22.
  - BYPASS=1 read of addr7 in that cycle -> 22.
- Scoreboard sequence:
  - issue addr3 -> busyR=1 and busy_cnt=1 next cycle.
  - issue addr3 again plus lane0 write addr3 in the same cycle -> busy stays 1, busy_cnt=1.
  - Write addr3 with no issue -> busy 0, busy_cnt=0.
  - issue addr0 -> busy_cnt stays 0.
- Issue addr4 and write addr9=77, then assert reset with RegWEn=1 writing addr9=99 -> after the edge Reg[9]=0, busy_cnt=0, all busyR=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the decode stage: NUM_WR write lanes,
// NUM_RD combinational read ports, optional write bypass and a busy scoreboard.
module regfile_mp #(
    parameter int REG_WIDTH      = 32,
    parameter int REG_DEPTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_RD         = 2,
    parameter int NUM_WR         = 1,
    parameter int BYPASS         = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_WR-1:0]                   RegWEn,
    input  logic [NUM_WR*REG_ADDR_WIDTH-1:0]    addrD,
    input  logic [NUM_WR*REG_WIDTH-1:0]         dataD,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0]    addrR,
    output logic [NUM_RD*REG_WIDTH-1:0]         dataR,
    output logic [NUM_RD-1:0]                   busyR,
    input  logic                                issue_en,
    input  logic [REG_ADDR_WIDTH-1:0]           issue_addr,
    output logic [REG_ADDR_WIDTH:0]             busy_cnt
);

    localparam int AW = REG_ADDR_WIDTH;

    logic [REG_WIDTH-1:0] regs [REG_DEPTH];
    logic [REG_DEPTH-1:0] busy;
    logic [REG_DEPTH-1:0] busyNext;
    logic [NUM_WR-1:0]    wrValid;

    function automatic logic [AW:0] popCount(input logic [REG_DEPTH-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < REG_DEPTH; i++) begin
            n = n + (AW+1)'(v[i]);
        end
        return n;
    endfunction

    // x0 is hardwired: a lane aimed at address 0 is treated as disabled.
    always_comb begin
        wrValid = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wrValid[k] = RegWEn[k] && (addrD[k*AW +: AW] != '0);
        end
    end

    // Writeback clears first, then issue sets, so issue wins on a collision.
    always_comb begin
        busyNext = busy;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wrValid[k]) begin
                busyNext[addrD[k*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en && (issue_addr != '0)) begin
            busyNext[issue_addr] = 1'b1;
        end
    end

    // Lanes are applied in ascending order so the highest lane wins a conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wrValid[k]) begin
                    regs[addrD[k*AW +: AW]] <= dataD[k*REG_WIDTH +: REG_WIDTH];
                end
            end
            busy     <= busyNext;
            busy_cnt <= popCount(busyNext);
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : gRead
        logic [AW-1:0]        ra;
        logic [REG_WIDTH-1:0] rv;

        assign ra = addrR[j*AW +: AW];

        always_comb begin
            rv = regs[ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wrValid[k] && (addrD[k*AW +: AW] == ra)) begin
                        rv = dataD[k*REG_WIDTH +: REG_WIDTH];
                    end
                end
            end
            if (ra == '0) begin
                rv = '0;
            end
        end

        assign dataR[j*REG_WIDTH +: REG_WIDTH] = rv;
        // Scoreboard read is deliberately not bypassed by a same-cycle writeback.
        assign busyR[j] = (ra != '0) && busy[ra];
    end

endmodule
